// File: rtl/spart_pkg.sv
// Shared SPART definitions: frame defaults,
// tx state encoding and counter sizing.
package spart_pkg;

  localparam int DATA_BITS_D  = 8;
  localparam int OVERSAMPLE_D = 16;
  localparam int STOP_BITS_D  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/spart_bit_timer.sv
// Oversample tick counter; flags the baud_en
// pulse that closes one bit period.
module spart_bit_timer
  import spart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_D
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic baud_en,
  output logic bit_done
);

  localparam int TW = clog2(OVERSAMPLE);
  localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);

  logic [TW-1:0] tick;

  assign bit_done = baud_en && (tick == LAST);

  // count baud pulses, wrapping on the bit boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick <= '0;
    end else if (clr) begin
      tick <= '0;
    end else if (baud_en) begin
      tick <= bit_done ? '0 : tick + 1'b1;
    end
  end

endmodule

// File: rtl/spart_tx.sv
// SPART transmitter: holding buffer, shifter
// and start/data/stop framing FSM.
module spart_tx
  import spart_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_D,
  parameter int OVERSAMPLE = OVERSAMPLE_D,
  parameter int STOP_BITS  = STOP_BITS_D
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_en,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 TxD,
  output logic                 TBR,
  output logic                 tx_busy,
  output logic                 overrun
);

  localparam int CW = clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] D_LAST = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] S_LAST = CW'(STOP_BITS - 1);

  tx_state_e state_q, state_d;

  logic [DATA_BITS-1:0] buf_q;
  logic                 buf_full_q;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                 txd_q, txd_d;
  logic                 overrun_q;
  logic                 load;
  logic                 wr_acc;
  logic                 bit_done;
  logic                 clr;

  assign wr_acc  = wr_en & ~buf_full_q;
  assign clr     = (state_q == IDLE);
  assign TxD     = txd_q;
  assign TBR     = ~buf_full_q;
  assign tx_busy = (state_q != IDLE);
  assign overrun = overrun_q;

  spart_bit_timer #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .baud_en (baud_en),
    .bit_done(bit_done)
  );

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sh_q      <= '0;
      bit_cnt_q <= '0;
      txd_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      bit_cnt_q <= bit_cnt_d;
      txd_q     <= txd_d;
    end
  end

  // holding buffer; a full buffer drops writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      overrun_q <= wr_en & buf_full_q;
      if (load) begin
        buf_full_q <= 1'b0;
      end else if (wr_acc) begin
        buf_full_q <= 1'b1;
        buf_q      <= tx_data;
      end
    end
  end

  // framing FSM: next state and next line value
  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    bit_cnt_d = bit_cnt_q;
    txd_d     = txd_q;
    load      = 1'b0;
    unique case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (buf_full_q) begin
          load    = 1'b1;
          sh_d    = buf_q;
          txd_d   = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (bit_done) begin
          state_d   = DATA;
          txd_d     = sh_q[0];
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_cnt_q == D_LAST) begin
            state_d   = STOP;
            txd_d     = 1'b1;
            bit_cnt_d = '0;
          end else begin
            sh_d      = sh_q >> 1;
            txd_d     = sh_q[1];
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (bit_done) begin
          if (bit_cnt_q == S_LAST) begin
            bit_cnt_d = '0;
            if (buf_full_q) begin
              load    = 1'b1;
              sh_d    = buf_q;
              txd_d   = 1'b0;
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

endmodule
